// File: rtl/i2c_read_burst_if.sv
// Request/response bundle between the sensor-polling controller and the I2C burst read engine.
// The controller holds the master side; the engine holds the slave side.
interface i2c_read_burst_if #(
  parameter int NB_W = 5
);
  logic            start;
  logic [6:0]      dev_addr;
  logic            use_reg;
  logic [7:0]      reg_addr;
  logic [NB_W-1:0] nbytes;
  logic [7:0]      rd_data;
  logic            rd_valid;
  logic            busy;
  logic            done;
  logic            ack_err;

  modport master (
    output start, dev_addr, use_reg, reg_addr, nbytes,
    input  rd_data, rd_valid, busy, done, ack_err
  );

  modport slave (
    input  start, dev_addr, use_reg, reg_addr, nbytes,
    output rd_data, rd_valid, busy, done, ack_err
  );
endinterface

// File: rtl/i2c_read_burst.sv
// I2C master burst read (optional pointer write + repeated START); bus activity starts the cycle after start.
// start is honoured only when idle and is dropped otherwise; no clock stretching, scl is never read back.
module i2c_read_burst #(
  parameter int HALF_PERIOD = 10,
  parameter int MAX_BYTES   = 16,
  parameter int NB_W        = $clog2(MAX_BYTES + 1)
) (
  input  logic            clk_1MHz,
  input  logic            rst,
  i2c_read_burst_if.slave bus,
  inout  wire             sda,
  output logic            scl
);

  localparam int HC_W = $clog2(HALF_PERIOD);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALF_PERIOD - 1);

  typedef enum logic [3:0] {
    IDLE, START, WBIT, WACK, RSTART, RBIT, MACK, STOP, DONE
  } state_t;

  typedef enum logic [1:0] {W_ADDR0, W_REG, W_ADDR_RD} wsel_t;

  state_t          state, state_d;
  logic [HC_W-1:0] hcnt;
  logic [1:0]      ph;
  logic [2:0]      bitcnt;
  wsel_t           wsel;
  logic [NB_W-1:0] bytes_left;
  logic [6:0]      dev_q;
  logic            use_reg_q;
  logic [7:0]      reg_q;
  logic [6:0]      shreg;
  logic [7:0]      rd_data_q;
  logic            rd_valid_q;
  logic            ack_err_q;

  logic            half_end;
  logic            ph_last;
  logic            phase_end;
  logic            sda_oe;
  logic [7:0]      tx_byte;
  logic [NB_W-1:0] n_clamped;

  assign half_end  = (hcnt == HC_LAST);
  assign ph_last   = (state == RSTART || state == STOP) ? (ph == 2'd2) : (ph == 2'd1);
  assign phase_end = half_end && ph_last;

  assign sda          = sda_oe ? 1'b0 : 1'bz;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.ack_err  = ack_err_q;
  assign bus.busy     = (state != IDLE) && (state != DONE);
  assign bus.done     = (state == DONE);

  always_comb begin
    n_clamped = bus.nbytes;
    if (bus.nbytes == '0) begin
      n_clamped = NB_W'(1);
    end else if (bus.nbytes > NB_W'(MAX_BYTES)) begin
      n_clamped = NB_W'(MAX_BYTES);
    end
  end

  always_comb begin
    case (wsel)
      W_ADDR0: tx_byte = {dev_q, ~use_reg_q};
      W_REG:   tx_byte = reg_q;
      default: tx_byte = {dev_q, 1'b1};
    endcase
  end

  always_ff @(posedge clk_1MHz) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // ph selects the half-period within a state: 0 is always the SCL-low half where one exists.
  always_comb begin
    state_d = state;
    scl     = 1'b1;
    sda_oe  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_d = START;
      end
      START: begin
        sda_oe = (ph == 2'd1);
        if (phase_end) state_d = WBIT;
      end
      WBIT: begin
        scl    = (ph != 2'd0);
        sda_oe = ~tx_byte[bitcnt];
        if (phase_end && bitcnt == 3'd0) state_d = WACK;
      end
      WACK: begin
        scl = (ph != 2'd0);
        if (phase_end) begin
          if (sda == 1'b1)                     state_d = STOP;
          else if (wsel == W_ADDR0 && use_reg_q) state_d = WBIT;
          else if (wsel == W_REG)               state_d = RSTART;
          else                                  state_d = RBIT;
        end
      end
      RSTART: begin
        scl    = (ph != 2'd0);
        sda_oe = (ph == 2'd2);
        if (phase_end) state_d = WBIT;
      end
      RBIT: begin
        scl = (ph != 2'd0);
        if (phase_end && bitcnt == 3'd0) state_d = MACK;
      end
      MACK: begin
        scl    = (ph != 2'd0);
        sda_oe = (bytes_left != NB_W'(1));
        if (phase_end) state_d = (bytes_left == NB_W'(1)) ? STOP : RBIT;
      end
      STOP: begin
        scl    = (ph != 2'd0);
        sda_oe = (ph != 2'd2);
        if (phase_end) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_1MHz) begin
    if (rst) begin
      hcnt       <= '0;
      ph         <= 2'd0;
      bitcnt     <= 3'd7;
      wsel       <= W_ADDR0;
      bytes_left <= '0;
      dev_q      <= '0;
      use_reg_q  <= 1'b0;
      reg_q      <= '0;
      shreg      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ack_err_q  <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;

      if (state == IDLE || state == DONE) begin
        hcnt <= '0;
        ph   <= 2'd0;
      end else if (half_end) begin
        hcnt <= '0;
        ph   <= ph_last ? 2'd0 : ph + 2'd1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end

      // bitcnt wraps 0 -> 7 at each byte end, so every byte starts at its MSB.
      if (state == IDLE) begin
        bitcnt <= 3'd7;
      end else if ((state == WBIT || state == RBIT) && phase_end) begin
        bitcnt <= bitcnt - 3'd1;
      end

      if (state == IDLE && bus.start) begin
        dev_q      <= bus.dev_addr;
        use_reg_q  <= bus.use_reg;
        reg_q      <= bus.reg_addr;
        bytes_left <= n_clamped;
        wsel       <= W_ADDR0;
        ack_err_q  <= 1'b0;
      end

      if (state == WACK && phase_end) begin
        if (sda == 1'b1) begin
          ack_err_q <= 1'b1;
        end else if (wsel == W_ADDR0 && use_reg_q) begin
          wsel <= W_REG;
        end else if (wsel == W_REG) begin
          wsel <= W_ADDR_RD;
        end
      end

      if (state == RBIT && ph == 2'd1 && half_end) begin
        shreg <= {shreg[5:0], sda};
        if (bitcnt == 3'd0) begin
          rd_data_q  <= {shreg, sda};
          rd_valid_q <= 1'b1;
        end
      end

      if (state == MACK && phase_end) begin
        bytes_left <= bytes_left - NB_W'(1);
      end
    end
  end

endmodule

// File: doc/i2c_read_burst.md
# i2c_read_burst

Parametrised I2C master read engine, successor to the single-byte read-frame block. Performs a 7-bit-addressed read of 1..MAX_BYTES bytes, with an optional register-pointer write and repeated START. It checks slave ACK on every address/pointer byte, and ACKs each received byte except the last, which gets a NACK. It sits between the sensor-polling controller and the open-drain SDA/SCL pads, on the 1 MHz system clock.

## Interface
Parameters:
- HALF_PERIOD, 10 — clk_1MHz cycles per SCL half-period (T); minimum 2.
- MAX_BYTES, 16 — largest burst length; minimum 1.
- NB_W, $clog2(MAX_BYTES+1) — width of nbytes.

Ports:
- clk_1MHz  in  1  system clock; all logic on rising edge. One clock domain.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request pulse; sampled only in IDLE.
- dev_addr  in  7  slave address; latched on accepted start.
- use_reg  in  1  1 = write reg_addr, then repeated START before the read; latched.
- reg_addr  in  8  register pointer; latched.
- nbytes  in  NB_W  bytes to read; latched. 0 is treated as 1; values above MAX_BYTES are clamped.
- sda  inout  1  open-drain: driven 0 or z, never 1.
- scl  out  1  SCL level; 1 = released.
- rd_data  out  8  last received byte, MSB first; held until the next byte.
- rd_valid  out  1  one-cycle pulse per received byte.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of transaction.
- ack_err  out  1  slave NACKed an address or pointer byte; valid with done, held until the next accepted start.

## Operation
- States: IDLE, START, WBIT, WACK, RSTART, RBIT, MACK, STOP, DONE. Sub-phases are timed by a half-period counter (0..T-1) and a bit counter (0..7).
- IDLE: scl=1, sda=z. When start=1, latch the inputs, clear ack_err and go to START.
- START (2T): T with SDA z/SCL 1, then T with SDA 0/SCL 1.
- WBIT (per bit, 2T): SCL 0 for T, with SDA set on the first cycle of the low phase; then SCL 1 for T.
  - First byte: {dev_addr, use_reg ? 0 : 1}.
  - Second byte (use_reg only): reg_addr.
- WACK (2T): SDA z, SCL low T then high T. Sample SDA on the last high cycle.
  - SDA=1: set ack_err and go to STOP.
  - SDA=0: continue to the next byte, RSTART, or RBIT as appropriate.
- RSTART (3T): SCL 0/SDA z for T, SCL 1/SDA z for T, SCL 1/SDA 0 for T. Then write byte {dev_addr, 1}.
- RBIT (8×2T): SDA z. Sample SDA on the last cycle of each SCL-high phase and shift it in MSB first. After bit 0: update rd_data and pulse rd_valid on the next cycle.
- MACK (2T): drive SDA 0 (ACK) if more bytes remain, else release SDA (NACK). Pulse SCL low T, high T. Decrement the byte count.
- STOP (3T): SCL 0/SDA 0 for T, SCL 1/SDA 0 for T, SCL 1/SDA z for T.
- DONE (1 cycle): done=1, busy=0, then IDLE.
- Reset: takes effect on the next clock edge in any state. It is legal mid-frame and aborts without a STOP. Bus recovery belongs to the caller.
- start while busy: ignored, not queued.
- Clock stretching and arbitration: not supported; scl is not read back.

## Timing
- Reset values: scl=1, sda=z, rd_data=0, rd_valid=0, busy=0, done=0, ack_err=0, state IDLE.
- Start accepted at cycle 0; busy=1 from cycle 1; the first SCL/SDA action (START phase) begins at cycle 1.
- Cycle count from cycle 1 to done:
  - Without pointer: (23 + 18·N)·T cycles.
  - With pointer: (62 + 18·N)·T cycles.
  - NACK abort after the first address byte: (20 + 3)·T, i.e. 2T + 16T + 2T + 3T STOP.
- rd_valid for byte k: the cycle after the last high cycle of its 8th bit. It is never coincident with done.
- A new start is accepted on the cycle after done (IDLE).

## Test plan
- T=4, use_reg=0, dev_addr=0x48, nbytes=1, slave ACKs and returns 0xA5 → address byte 0x91 on the bus; rd_data=0xA5 with one rd_valid; master NACK; STOP; done 164 cycles after busy rises; ack_err=0.
- T=4, use_reg=1, dev_addr=0x50, reg_addr=0x10, nbytes=3, slave returns 0x01,0x02,0x03 → bus shows 0xA0, 0x10, repeated START, 0xA1; three rd_valid pulses in order; ACK, ACK, NACK; done at 464 cycles.
- No slave (SDA pulled up), nbytes=4 → ack_err=1 with done after 92 cycles; no rd_valid; STOP present on the bus.
- nbytes=0 and nbytes=MAX_BYTES+5 → exactly 1 and MAX_BYTES bytes read, respectively.
- start pulsed mid-transfer, then rst asserted during RBIT → the second start is ignored; after rst, scl=1, sda=z, busy=0, and a new start runs normally.
- SDA check at every SCL-high cycle across all of the above → SDA changes only while SCL=0, except at START, repeated START and STOP edges.
